sid_table_sched: RTL and testbench
==================================

# sid_table_sched

Time-multiplexed scheduler that shares one combined-waveform lookup table (the `_st`/`p_t`/`ps_`/`pst` tables) among all voices of the SID core. Each `ce_1m` sample slot triggers one scan. The scan presents each voice's accumulator-derived table addresses to the single table instance, waits out the table latency, and latches the four 8-bit results into that voice's output slot. It sits between the `sid_voice` instances and `sid_tables`, replacing the ad-hoc per-slot counter so voice count and table latency are parameters (e.g. dual-SID, 6 voices).

## Interface
- `NVOICE`, default 3: number of voices scanned per slot (1..8).
- `LAT`, default 2: table read latency in clocks (≥1).
- `AW`, default 12: table address width.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce_1m` in 1: sample-slot strobe; starts a scan.
- `en` in 1: scan enable; when low, `ce_1m` is ignored.
- `overrun_clr` in 1: clears `overrun`.
- `acc_ps_in` in NVOICE*AW: per-voice pulse/saw table address; voice v occupies bits [AW*v+AW-1 : AW*v].
- `acc_t_in` in NVOICE*AW: per-voice triangle table address, same packing.
- `tbl_acc_ps` out AW: registered table address (ps).
- `tbl_acc_t` out AW: registered table address (t).
- `tbl_st`, `tbl_pt`, `tbl_ps`, `tbl_pst` in 8 each: table read data.
- `st_out`, `pt_out`, `ps_out`, `pst_out` out NVOICE*8 each: per-voice latched results; voice v occupies bits [8v+7:8v].
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse at scan completion.
- `overrun` out 1: sticky; set when `ce_1m` arrives during a scan.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE. Voice index `idx` runs 0..NVOICE-1. WAIT counter runs 0..LAT-1.
- IDLE: when `ce_1m`=1 and `en`=1, set `idx`←0 and go to ISSUE.
- ISSUE (1 cycle):
  - `tbl_acc_ps`←`acc_ps_in[idx]` and `tbl_acc_t`←`acc_t_in[idx]`.
  - Addresses are snapshotted here, so later input changes do not affect this voice.
  - Go to WAIT.
- WAIT (exactly LAT cycles): table addresses are held. Then go to CAPTURE.
- CAPTURE (1 cycle): at the closing edge, the four `tbl_*` inputs are written into slot `idx` of the matching outputs.
  - If `idx`=NVOICE-1: go to IDLE and assert `done` for the next cycle.
  - Otherwise: `idx`←`idx`+1 and go to ISSUE.
- Table contract: data for an address visible in cycle a is valid in cycle a+LAT.
- Output slots not yet captured in the current scan keep their previous-scan values. Outputs change only at CAPTURE edges.
- `busy` = (state ≠ IDLE), registered.
- `ce_1m` while busy does not restart the scan. It sets `overrun`=1 (only if `en`=1).
- `overrun` clears on `overrun_clr`=1. If a set event and clear occur in the same cycle, set wins.
- `en` falling mid-scan does not abort the scan; it only blocks new starts.
- `ce_1m` in the cycle where `done`=1 (state is IDLE) is accepted normally and does not set `overrun`.
- Reset (async, any time, including mid-scan):
  - state←IDLE, `idx`←0.
  - All outputs←0 (`tbl_acc_*`, result buses, `busy`, `done`, `overrun`).
  - No `done` is generated for an interrupted scan.

## Timing
- `ce_1m` sampled high in cycle 0 (IDLE):
  - ISSUE for voice v occurs in cycle 1+v*(LAT+2).
  - WAIT occupies the next LAT cycles.
  - CAPTURE occurs in cycle (v+1)*(LAT+2).
- Result slot v becomes visible in cycle (v+1)*(LAT+2)+1.
- `done` is high in cycle 1+NVOICE*(LAT+2). Defaults give cycle 13.
- `busy` is high in cycles 1 .. NVOICE*(LAT+2). Defaults give cycles 1..12.
- Scan length must be less than the `ce_1m` period. This holds at 32 MHz with defaults; a violation is flagged by `overrun`.

## Test plan
- Reset: hold `reset_n`=0 with random inputs → all outputs 0, `busy`=0. Release → outputs remain 0 until the first scan.
- Basic scan:
  - Setup: defaults, `en`=1. Table model returns `tbl_st`=`tbl_acc_ps[7:0]` and `tbl_pst`=`tbl_acc_t[7:0]` with LAT=2. `acc_ps_in` voices 0/1/2 = 12'h123/12'h456/12'h789.
  - Stimulus: `ce_1m` in cycle 0.
  - Required: `busy` high cycles 1–12. `st_out`=24'h895623 by cycle 13. `done` high only in cycle 13.
- Snapshot:
  - Stimulus: change voice 2's `acc_ps_in` from 12'h789 to 12'h7AB in cycle 6 (voice 1 WAIT).
  - Required: `st_out[23:16]`=8'hAB. Voice 0/1 results unchanged.
- Overrun:
  - Stimulus: `ce_1m` again in cycle 5.
  - Required: scan continues unchanged, `done` in cycle 13, `overrun`=1 from cycle 6.
  - Follow-up: `overrun_clr` in cycle 20 → `overrun`=0 in cycle 21. `overrun_clr` and `ce_1m`-during-busy in the same cycle → `overrun` stays 1.
- Reset mid-scan:
  - Stimulus: `reset_n`=0 in cycle 7.
  - Required: outputs 0 immediately (asynchronous), no `done` pulse. A new `ce_1m` after release completes a normal 13-cycle scan.
- Enable and back-to-back:
  - `en`=0 with `ce_1m` → `busy`, `done`, `overrun` stay 0.
  - `en`=1 with `ce_1m` in cycle 13 → second scan starts, `done` in cycle 26, `overrun`=0.
  - NVOICE=6, LAT=1 → `done` in cycle 19.

Source files
------------

// File: rtl/sid_table_sched.sv
// sid_table_sched: shares one combined-waveform table among NVOICE voices, one scan per ce_1m
// ports: clk, reset_n (async low); ce_1m/en start a scan; overrun_clr clears overrun;
//        acc_ps_in/acc_t_in per-voice addresses; tbl_acc_ps/tbl_acc_t to table; tbl_* table data;
//        st_out/pt_out/ps_out/pst_out per-voice results; busy, done pulse, sticky overrun
module sid_table_sched #(
   parameter int NVOICE = 3,
   parameter int LAT    = 2,
   parameter int AW     = 12
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ce_1m,
   input  logic                 en,
   input  logic                 overrun_clr,
   input  logic [NVOICE*AW-1:0] acc_ps_in,
   input  logic [NVOICE*AW-1:0] acc_t_in,
   output logic [AW-1:0]        tbl_acc_ps,
   output logic [AW-1:0]        tbl_acc_t,
   input  logic [7:0]           tbl_st,
   input  logic [7:0]           tbl_pt,
   input  logic [7:0]           tbl_ps,
   input  logic [7:0]           tbl_pst,
   output logic [NVOICE*8-1:0]  st_out,
   output logic [NVOICE*8-1:0]  pt_out,
   output logic [NVOICE*8-1:0]  ps_out,
   output logic [NVOICE*8-1:0]  pst_out,
   output logic                 busy,
   output logic                 done,
   output logic                 overrun
);
   localparam int IW = NVOICE > 1 ? $clog2(NVOICE) : 1;
   localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;
   state_t state;
   logic [IW-1:0] idx;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         tbl_acc_ps <= '0;
         tbl_acc_t  <= '0;
         st_out     <= '0;
         pt_out     <= '0;
         ps_out     <= '0;
         pst_out    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         done <= 1'b0;
         // a start request during a scan is lost; flag it, and let it beat a same-cycle clear
         if (state != IDLE && ce_1m && en) overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
         case (state)
            IDLE: if (ce_1m && en) begin
               idx   <= '0;
               state <= ISSUE;
               busy  <= 1'b1;
            end
            ISSUE: begin
               tbl_acc_ps <= acc_ps_in[AW*idx +: AW];
               tbl_acc_t  <= acc_t_in[AW*idx +: AW];
               cnt        <= '0;
               state      <= WAIT;
            end
            WAIT: if (cnt == CW'(LAT - 1)) state <= CAPTURE;
                  else cnt <= cnt + 1'b1;
            CAPTURE: begin
               st_out[8*idx +: 8]  <= tbl_st;
               pt_out[8*idx +: 8]  <= tbl_pt;
               ps_out[8*idx +: 8]  <= tbl_ps;
               pst_out[8*idx +: 8] <= tbl_pst;
               if (idx == IW'(NVOICE - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= ISSUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sid_table_sched.sv
// tb_sid_table_sched: directed checks of the shared-table scheduler (default and 6-voice/LAT1 instances)
module tb_sid_table_sched;
   logic clk = 1'b0;
   logic reset_n, ce_1m, en, overrun_clr;
   logic [35:0] acc_ps_in, acc_t_in;
   logic [11:0] tbl_acc_ps, tbl_acc_t;
   logic [7:0] tbl_st, tbl_pt, tbl_ps, tbl_pst;
   logic [23:0] st_out, pt_out, ps_out, pst_out;
   logic busy, done, overrun;
   logic ce6, en6, clr6;
   logic [71:0] acc_ps6, acc_t6;
   logic [11:0] tbl_acc_ps6, tbl_acc_t6;
   logic [47:0] st6, pt6, ps6, pst6;
   logic busy6, done6, overrun6;
   logic [11:0] p1, p2, t1, t2, q1, u1;
   int n, fails;

   always #5 clk = ~clk;

   sid_table_sched dut (
      .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m), .en(en), .overrun_clr(overrun_clr),
      .acc_ps_in(acc_ps_in), .acc_t_in(acc_t_in), .tbl_acc_ps(tbl_acc_ps), .tbl_acc_t(tbl_acc_t),
      .tbl_st(tbl_st), .tbl_pt(tbl_pt), .tbl_ps(tbl_ps), .tbl_pst(tbl_pst),
      .st_out(st_out), .pt_out(pt_out), .ps_out(ps_out), .pst_out(pst_out),
      .busy(busy), .done(done), .overrun(overrun));

   sid_table_sched #(.NVOICE(6), .LAT(1), .AW(12)) dut6 (
      .clk(clk), .reset_n(reset_n), .ce_1m(ce6), .en(en6), .overrun_clr(clr6),
      .acc_ps_in(acc_ps6), .acc_t_in(acc_t6), .tbl_acc_ps(tbl_acc_ps6), .tbl_acc_t(tbl_acc_t6),
      .tbl_st(q1[7:0]), .tbl_pt(q1[11:4]), .tbl_ps(~q1[7:0]), .tbl_pst(u1[7:0]),
      .st_out(st6), .pt_out(pt6), .ps_out(ps6), .pst_out(pst6),
      .busy(busy6), .done(done6), .overrun(overrun6));

   always @(posedge clk) begin
      p1 <= tbl_acc_ps;
      p2 <= p1;
      t1 <= tbl_acc_t;
      t2 <= t1;
      q1 <= tbl_acc_ps6;
      u1 <= tbl_acc_t6;
   end
   assign tbl_st  = p2[7:0];
   assign tbl_pt  = p2[11:4];
   assign tbl_ps  = ~p2[7:0];
   assign tbl_pst = t2[7:0];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      n = 0;
      fails = 0;
      reset_n = 1'b0;
      en = 1'(($urandom));
      ce_1m = 1'(($urandom));
      overrun_clr = 1'(($urandom));
      acc_ps_in = {4'($urandom), 32'($urandom)};
      acc_t_in = {4'($urandom), 32'($urandom)};
      ce6 = 1'(($urandom));
      en6 = 1'b1;
      clr6 = 1'b0;
      acc_ps6 = {8'($urandom), 32'($urandom), 32'($urandom)};
      acc_t6 = {8'($urandom), 32'($urandom), 32'($urandom)};
      repeat (3) tick;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_tbl_ps", tbl_acc_ps, 0);
      chk("rst_tbl_t", tbl_acc_t, 0);
      chk("rst_st", st_out, 0);
      chk("rst_pt", pt_out, 0);
      chk("rst_ps", ps_out, 0);
      chk("rst_pst", pst_out, 0);
      chk("rst_busy6", busy6, 0);
      chk("rst_st6", st6, 0);
      ce_1m = 1'b0;
      ce6 = 1'b0;
      en = 1'b1;
      overrun_clr = 1'b0;
      acc_ps_in = {12'h789, 12'h456, 12'h123};
      acc_t_in = {12'hABC, 12'hDEF, 12'h321};
      acc_ps6 = {12'h0F6, 12'h0E5, 12'h0D4, 12'h0C3, 12'h0B2, 12'h0A1};
      acc_t6 = '0;
      reset_n = 1'b1;
      repeat (3) tick;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_st", st_out, 0);
      chk("post_rst_tbl", tbl_acc_ps, 0);

      // basic scan
      ce_1m = 1'b1;
      tick;
      ce_1m = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         chk($sformatf("basic_busy_c%0d", c), busy, c <= 12);
         chk($sformatf("basic_done_c%0d", c), done, c == 13);
         if (c == 2) chk("basic_addr_v0", tbl_acc_ps, 12'h123);
         if (c == 9) chk("basic_addr_hold_v1", tbl_acc_ps, 12'h456);
         if (c == 5) chk("basic_v0_only", st_out, 24'h000023);
         if (c < 13) tick;
      end
      chk("basic_st", st_out, 24'h895623);
      chk("basic_pt", pt_out, 24'h784512);
      chk("basic_ps", ps_out, 24'h76A9DC);
      chk("basic_pst", pst_out, 24'hBCEF21);
      chk("basic_tbl_t", tbl_acc_t, 12'hABC);
      chk("basic_overrun", overrun, 0);
      repeat (2) tick;

      // snapshot of voice 2 plus overrun from a mid-scan ce_1m
      ce_1m = 1'b1;
      tick;
      ce_1m = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         if (c == 5) ce_1m = 1'b1;
         if (c == 6) begin
            ce_1m = 1'b0;
            acc_ps_in[35:24] = 12'h7AB;
            chk("snap_v01_kept", st_out[15:0], 16'h5623);
         end
         chk($sformatf("ovr_c%0d", c), overrun, c >= 6);
         chk($sformatf("ovr_busy_c%0d", c), busy, c <= 12);
         chk($sformatf("ovr_done_c%0d", c), done, c == 13);
         tick;
         if (c == 13) break;
      end
      chk("snap_st", st_out, 24'hAB5623);
      chk("snap_pt", pt_out, 24'h7A4512);
      chk("snap_ps", ps_out, 24'h54A9DC);
      repeat (6) tick;
      overrun_clr = 1'b1;
      chk("ovr_before_clr", overrun, 1);
      tick;
      overrun_clr = 1'b0;
      chk("ovr_cleared", overrun, 0);
      ce_1m = 1'b1;
      tick;
      overrun_clr = 1'b1;
      tick;
      ce_1m = 1'b0;
      overrun_clr = 1'b0;
      chk("ovr_set_wins", overrun, 1);
      repeat (11) tick;
      chk("ovr_scan_done", done, 1);
      overrun_clr = 1'b1;
      tick;
      overrun_clr = 1'b0;
      chk("ovr_clr2", overrun, 0);

      // asynchronous reset in the middle of a scan
      ce_1m = 1'b1;
      tick;
      ce_1m = 1'b0;
      repeat (6) tick;
      chk("mid_busy_before", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_st", st_out, 0);
      chk("mid_rst_ps", ps_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_tbl", tbl_acc_ps, 0);
      tick;
      reset_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
         chk($sformatf("mid_no_done_%0d", c), done, 0);
         chk($sformatf("mid_idle_%0d", c), busy, 0);
         tick;
      end
      ce_1m = 1'b1;
      tick;
      ce_1m = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         chk($sformatf("rescan_done_c%0d", c), done, c == 13);
         if (c < 13) tick;
      end
      chk("rescan_st", st_out, 24'hAB5623);

      // enable low blocks starts
      tick;
      en = 1'b0;
      ce_1m = 1'b1;
      tick;
      ce_1m = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         chk($sformatf("en0_busy_%0d", c), busy, 0);
         chk($sformatf("en0_done_%0d", c), done, 0);
         chk($sformatf("en0_ovr_%0d", c), overrun, 0);
         tick;
      end

      // back-to-back: ce_1m in the done cycle, en dropped mid second scan
      en = 1'b1;
      ce_1m = 1'b1;
      tick;
      ce_1m = 1'b0;
      for (int c = 1; c <= 26; c++) begin
         if (c == 13) ce_1m = 1'b1;
         if (c == 14) ce_1m = 1'b0;
         if (c == 16) en = 1'b0;
         chk($sformatf("b2b_done_c%0d", c), done, c == 13 || c == 26);
         chk($sformatf("b2b_busy_c%0d", c), busy, (c >= 1 && c <= 12) || (c >= 14 && c <= 25));
         chk($sformatf("b2b_ovr_c%0d", c), overrun, 0);
         if (c < 26) tick;
      end
      chk("b2b_st", st_out, 24'hAB5623);
      en = 1'b1;

      // six voices, one-cycle table
      ce6 = 1'b1;
      tick;
      ce6 = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         chk($sformatf("v6_done_c%0d", c), done6, c == 19);
         chk($sformatf("v6_busy_c%0d", c), busy6, c <= 18);
         if (c == 7) chk("v6_partial", st6, 48'h00000000B2A1);
         if (c < 19) tick;
      end
      chk("v6_st", st6, 48'hF6E5D4C3B2A1);
      chk("v6_pt", pt6, 48'h0F0E0D0C0B0A);
      chk("v6_pst", pst6, 48'h0);
      chk("v6_overrun", overrun6, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
      $finish;
   end
endmodule
